// File: rtl/ad_axis_inf_rx_pkg.sv
// Shared helpers for the push-to-AXI-stream receive buffer.
// Optional build feature: AD_AXIS_INF_RX_BUF_LEVEL_EN (level/almost_full ports).
package ad_axis_inf_rx_pkg;

  // Number of storage entries for a given address width.
  function automatic int unsigned rx_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Stored entry width: the data word plus its end-of-packet marker.
  function automatic int unsigned rx_entry_width(input int unsigned data_width);
    return data_width + 32'd1;
  endfunction

endpackage

// File: rtl/ad_axis_inf_rx_buf_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module ad_axis_inf_rx_buf_mem
  import ad_axis_inf_rx_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  localparam int DEPTH = int'(rx_depth(ADDR_WIDTH));

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  // Store the incoming entry at the write address when enabled.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ad_axis_inf_rx_buf.sv
// Push-interface to AXI-stream receive buffer with registered output stage.
// Free-running valid/last/data pushes (no back-pressure) are queued in a
// 2**ADDR_WIDTH deep buffer; a sticky ovf flag records dropped words.
// Optional build feature: define AD_AXIS_INF_RX_BUF_LEVEL_EN to add the
// registered level and almost_full outputs.
module ad_axis_inf_rx_buf
  import ad_axis_inf_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ovf_clr,
  output logic                  ovf,
  output logic                  inf_valid,
  output logic                  inf_last,
  output logic [DATA_WIDTH-1:0] inf_data,
  input  logic                  inf_ready
`ifdef AD_AXIS_INF_RX_BUF_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
`endif
);

  localparam int DEPTH       = int'(rx_depth(ADDR_WIDTH));
  localparam int ENTRY_WIDTH = int'(rx_entry_width(DATA_WIDTH));
  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // Pointers carry one extra bit so a full buffer is distinguishable
  // from an empty one.
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   w_wptr_nxt;
  logic [ADDR_WIDTH:0]   w_rptr_nxt;
  logic [ADDR_WIDTH:0]   w_used;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_en;
  logic                  w_drop;
  logic                  w_ready_s;
  logic                  w_rd_en;
  entry_t                w_wr_entry;
  entry_t                w_rd_entry;
  logic [ENTRY_WIDTH-1:0] w_rd_bits;

  logic                  r_ovf;
  logic                  r_inf_valid;
  logic                  r_inf_last;
  logic [DATA_WIDTH-1:0] r_inf_data;

  // Full/empty come from registered pointers only, so a pop in the same
  // cycle never frees a slot for the concurrent push.
  assign w_used  = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_used == DEPTH_P);

  assign w_wr_en = valid & ~w_full;
  assign w_drop  = valid & w_full;

  // The output register may advance when it is empty or being consumed.
  assign w_ready_s = inf_ready | ~r_inf_valid;
  assign w_rd_en   = w_ready_s & ~w_empty;

  assign w_wptr_nxt = r_wptr + {{ADDR_WIDTH{1'b0}}, w_wr_en};
  assign w_rptr_nxt = r_rptr + {{ADDR_WIDTH{1'b0}}, w_rd_en};

  assign w_wr_entry.last = last;
  assign w_wr_entry.data = data;
  assign w_rd_entry      = entry_t'(w_rd_bits);

  ad_axis_inf_rx_buf_mem #(
    .WIDTH      (ENTRY_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_rd_bits)
  );

  // Advance write/read pointers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
    end
  end

  // Output register: load the head entry, go idle when drained, hold under stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_inf_valid <= 1'b0;
      r_inf_last  <= 1'b0;
      r_inf_data  <= '0;
    end else if (w_rd_en) begin
      r_inf_valid <= 1'b1;
      r_inf_last  <= w_rd_entry.last;
      r_inf_data  <= w_rd_entry.data;
    end else if (w_ready_s) begin
      r_inf_valid <= 1'b0;
      r_inf_last  <= 1'b0;
      r_inf_data  <= '0;
    end
  end

  // Sticky overflow: a drop sets it and beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf       = r_ovf;
  assign inf_valid = r_inf_valid;
  assign inf_last  = r_inf_last;
  assign inf_data  = r_inf_data;

`ifdef AD_AXIS_INF_RX_BUF_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AFULL_P = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] w_level_nxt;
  logic [ADDR_WIDTH:0] r_level;
  logic                r_almost_full;

  assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

  // Track the buffered word count (output register excluded) alongside the pointers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_level_nxt;
      r_almost_full <= (w_level_nxt >= AFULL_P);
    end
  end

  assign level       = r_level;
  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_ad_axis_inf_rx_buf.sv
// Self-checking bench for ad_axis_inf_rx_buf (default parameters).
// A queue-based reference model predicts the outputs after every edge;
// directed steps cover latency, fill/drain, back-pressure, wrap, ovf clear
// race and reset mid-packet, followed by a randomized phase.
module tb_ad_axis_inf_rx_buf;

  localparam int DW     = 16;
  localparam int AW     = 3;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid;
  logic          last;
  logic [DW-1:0] data;
  logic          ovf_clr;
  logic          ovf;
  logic          inf_valid;
  logic          inf_last;
  logic [DW-1:0] inf_data;
  logic          inf_ready;
`ifdef AD_AXIS_INF_RX_BUF_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: buffered entries and the output register.
  logic [DW:0]   mq[$];
  logic          mV;
  logic          mL;
  logic [DW-1:0] mD;
  logic          mOvf;

  // Words the DUT handed over (valid & ready), as {last, data}.
  logic [DW:0]   delivered[$];
  logic [DW:0]   sent[$];

  ad_axis_inf_rx_buf #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid       (valid),
    .last        (last),
    .data        (data),
    .ovf_clr     (ovf_clr),
    .ovf         (ovf),
    .inf_valid   (inf_valid),
    .inf_last    (inf_last),
    .inf_data    (inf_data),
    .inf_ready   (inf_ready)
`ifdef AD_AXIS_INF_RX_BUF_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Queue-level model of one clock edge.
  task automatic modelEdge(input logic iValid, input logic iLast, input logic [DW-1:0] iData,
                           input logic iReady, input logic iClr, input logic iRstn);
    logic full;
    logic readyS;
    logic [DW:0] e;
    if (!iRstn) begin
      mq.delete();
      mV = 1'b0; mL = 1'b0; mD = '0; mOvf = 1'b0;
    end else begin
      full   = (mq.size() == DEPTH);
      readyS = iReady || !mV;
      if (readyS) begin
        if (mq.size() > 0) begin
          e  = mq.pop_front();
          mV = 1'b1; mL = e[DW]; mD = e[DW-1:0];
        end else begin
          mV = 1'b0; mL = 1'b0; mD = '0;
        end
      end
      if (iValid && !full) mq.push_back({iLast, iData});
      if (iValid && full) mOvf = 1'b1;
      else if (iClr)      mOvf = 1'b0;
    end
  endtask

  task automatic checkOutput(input logic pV, input logic pL, input logic [DW-1:0] pD,
                             input logic pReady, input logic pRstn);
    chk("inf_valid", {31'd0, inf_valid}, {31'd0, mV});
    chk("inf_last",  {31'd0, inf_last},  {31'd0, mL});
    chk("inf_data",  {16'd0, inf_data},  {16'd0, mD});
    chk("ovf",       {31'd0, ovf},       {31'd0, mOvf});
`ifdef AD_AXIS_INF_RX_BUF_LEVEL_EN
    chk("level",       {28'd0, level},       32'(mq.size()));
    chk("almost_full", {31'd0, almost_full}, {31'd0, mq.size() >= AFULL});
`endif
    if (pV && !pReady && pRstn) begin
      chk("stall_valid", {31'd0, inf_valid}, 32'd1);
      chk("stall_data",  {16'd0, inf_data},  {16'd0, pD});
      chk("stall_last",  {31'd0, inf_last},  {31'd0, pL});
    end
  endtask

  task automatic applyStimulus(input logic iValid, input logic iLast, input logic [DW-1:0] iData,
                               input logic iReady, input logic iClr, input logic iRstn);
    logic pV, pL;
    logic [DW-1:0] pD;
    valid = iValid; last = iLast; data = iData;
    inf_ready = iReady; ovf_clr = iClr; rstn = iRstn;
    pV = inf_valid; pL = inf_last; pD = inf_data;
    if (inf_valid && iReady && iRstn) delivered.push_back({inf_last, inf_data});
    @(posedge clk);
    modelEdge(iValid, iLast, iData, iReady, iClr, iRstn);
    #1;
    checkOutput(pV, pL, pD, iReady, iRstn);
  endtask

  task automatic checkSequence(input string tag);
    chk({tag, "_count"}, 32'(delivered.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < delivered.size(); i++) begin
      chk({tag, "_word"}, {15'd0, delivered[i]}, {15'd0, sent[i]});
    end
  endtask

  initial begin
    logic [DW-1:0] r;
    valid = 0; last = 0; data = '0; ovf_clr = 0; inf_ready = 0; rstn = 0;
    mV = 0; mL = 0; mD = '0; mOvf = 0;

    // Reset state
    applyStimulus(0, 0, '0, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 0);
    chk("reset_valid", {31'd0, inf_valid}, 32'd0);
    chk("reset_ovf",   {31'd0, ovf},       32'd0);

    // Single word: visible two edges after the push
    applyStimulus(1, 1, 16'h1234, 1, 0, 1);
    chk("t1_edge1_valid", {31'd0, inf_valid}, 32'd0);
    applyStimulus(0, 0, '0, 1, 0, 1);
    chk("t1_edge2_valid", {31'd0, inf_valid}, 32'd1);
    chk("t1_edge2_data",  {16'd0, inf_data},  32'h1234);
    chk("t1_edge2_last",  {31'd0, inf_last},  32'd1);
    applyStimulus(0, 0, '0, 1, 0, 1);
    chk("t1_edge3_valid", {31'd0, inf_valid}, 32'd0);
    chk("t1_edge3_data",  {16'd0, inf_data},  32'd0);

    // Fill then drain: 9 words kept, the 10th dropped
    delivered.delete(); sent.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, (i == 8), DW'(i), 0, 0, 1);
      if (i < 9) sent.push_back({(i == 8), DW'(i)});
    end
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_head", {16'd0, inf_data}, 32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, '0, 1, 0, 1);
    checkSequence("t2_drain");

    // ovf clear race: set beats clear, plain clear works
    applyStimulus(0, 0, '0, 1, 1, 1);
    chk("t5_clear", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, DW'(16'h100 + i), 0, 0, 1);
    chk("t5_nodrop", {31'd0, ovf}, 32'd0);
    applyStimulus(1, 1, 16'hDEAD, 0, 1, 1);
    chk("t5_race", {31'd0, ovf}, 32'd1);
    applyStimulus(0, 0, '0, 0, 1, 1);
    chk("t5_clear2", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, '0, 1, 0, 1);

    // Back-pressure: ready toggles every cycle, data must hold while stalled
    delivered.delete(); sent.delete();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, (i % 8 == 7), DW'(i), 1, 0, 1);
      applyStimulus(0, 0, '0, 0, 0, 1);
      sent.push_back({(i % 8 == 7), DW'(i)});
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, '0, 1, 0, 1);
      applyStimulus(0, 0, '0, 0, 0, 1);
    end
    checkSequence("t3_bp");
    chk("t3_ovf", {31'd0, ovf}, 32'd0);

    // Pointer wrap at full rate
    delivered.delete(); sent.delete();
    for (int i = 0; i < 100; i++) begin
      r = DW'($urandom);
      applyStimulus(1, r[0], r, 1, 0, 1);
      sent.push_back({r[0], r});
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0, 1);
    checkSequence("t4_wrap");
    chk("t4_ovf", {31'd0, ovf}, 32'd0);

    // Reset mid-packet discards everything
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, DW'(16'h500 + i), 0, 0, 1);
    applyStimulus(1, 1, 16'hBEEF, 0, 1, 0);
    chk("t6_valid", {31'd0, inf_valid}, 32'd0);
    chk("t6_ovf",   {31'd0, ovf},       32'd0);
    delivered.delete();
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, 1, 0, 1);
    chk("t6_stale", 32'(delivered.size()), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = DW'($urandom);
      applyStimulus(($urandom % 4) != 0, r[15], r, $urandom % 2 == 0,
                    ($urandom % 16) == 0, ($urandom % 64) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_axis_inf_rx_buf.md
Name: ad_axis_inf_rx_buf

Overview:
Parametrised successor of the fixed 8-deep push-to-AXI-stream receive buffer. Accepts a free-running valid/last/data push interface with no back-pressure and presents it as an AXI-stream master through a registered output stage. Adds:
- configurable width and depth
- true full/empty tracking using an extra pointer bit
- sticky overflow detection with software clear
Sits between ADC/packetiser capture logic and DMA or stream interconnect.

Parameters:
DATA_WIDTH, 16, width of data and inf_data in bits (>=1)
ADDR_WIDTH, 3, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH (1..10)
AFULL_THRESH, 6, level at or above which almost_full asserts (used only with the optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  reset, synchronous, active-low
valid  input  1  push strobe, one word per cycle when high
last  input  1  end-of-packet marker for the pushed word
data  input  DATA_WIDTH  pushed word
ovf_clr  input  1  clears the sticky ovf flag
ovf  output  1  sticky overflow flag
inf_valid  output  1  AXI-stream tvalid
inf_last  output  1  AXI-stream tlast
inf_data  output  DATA_WIDTH  AXI-stream tdata
inf_ready  input  1  AXI-stream tready
level  output  ADDR_WIDTH+1  buffered word count (optional feature only)
almost_full  output  1  level >= AFULL_THRESH (optional feature only)

Behaviour:
- Reset (rstn=0 at a clk edge):
  - wptr, rptr, ovf, inf_valid, inf_last, inf_data all 0; level 0, almost_full 0.
  - Storage contents are not reset.
  - Reset wins over every other event in the same cycle.
  - Reset mid-packet discards all buffered words; no partial packet is emitted afterwards.
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits; address is the low ADDR_WIDTH bits; both wrap naturally modulo 2**(ADDR_WIDTH+1).
  - empty = (wptr == rptr)
  - full = (wptr - rptr) == DEPTH
- Write:
  - Performed when valid=1 and full=0: stores {last, data} at wptr, then wptr+1.
  - When valid=1 and full=1: word dropped, wptr unchanged, ovf set next edge.
  - full is evaluated on registered pointers only. A write in the same cycle as a pop while full is still dropped; there is no combinational path from inf_ready to write enable.
- Read/output stage: ready_s = inf_ready | ~inf_valid.
  - When ready_s=1 and not empty: load inf_data/inf_last from rptr, inf_valid=1, rptr+1.
  - When ready_s=1 and empty: inf_valid=0, inf_last=0, inf_data=0.
  - When ready_s=0: outputs and rptr hold. AXI rule: data and last are stable while valid=1 and ready=0.
- Latency: valid at cycle N reaches inf_valid=1 at the edge ending cycle N+1, i.e. 2 edges, when the buffer and output stage are idle.
- Throughput: 1 word/cycle sustained when inf_ready=1.
- Capacity: DEPTH words in the buffer plus 1 in the output register.
- ovf:
  - Set on any dropped word.
  - Cleared by ovf_clr=1.
  - A drop coinciding with ovf_clr leaves ovf=1 (set wins).
- Word integrity: last travels with its word unchanged. Drops are never reported by altering last.

Optional Feature:
Macro AD_AXIS_INF_RX_BUF_LEVEL_EN.
- Defined:
  - level and almost_full ports exist.
  - level = wptr - rptr, registered; updated on the same edge as the pointers and excludes the output-register word.
  - almost_full = (level >= AFULL_THRESH), registered.
- Undefined: both ports and their logic are absent; AFULL_THRESH is unused.

Decomposition:
- Package ad_axis_inf_rx_pkg:
  - function/constant for DEPTH from ADDR_WIDTH
  - typedef of the stored entry struct {last, data} parametrised by DATA_WIDTH via localparam in the module
- One sub-module, ad_axis_inf_rx_buf_mem: simple dual-port register array with 1 write port and 1 async read port, parametrised by width and ADDR_WIDTH.
- Pointer, full/empty, ovf and output-stage logic stay in the top module.

Test Plan:
1. Single word: rstn released, valid=1 one cycle with data=0x1234, last=1, inf_ready=1 -> inf_valid=1 with inf_data=0x1234, inf_last=1 exactly 2 edges later, then inf_valid=0, inf_data=0.
2. Fill then drain (ADDR_WIDTH=3): inf_ready=0, push 10 words 0..9 -> words 0..8 retained (8 buffer + 1 output reg), word 9 dropped, ovf=1. Raise inf_ready -> 0..8 emitted in order, no gaps.
3. Back-pressure stability: stream 0x00..0x1F with inf_ready toggling 1010 -> inf_data/inf_last never change while inf_valid=1 and inf_ready=0; all 32 words delivered.
4. Pointer wrap: 100 words pushed at 1/cycle with inf_ready=1 -> output sequence identical, ovf=0. With LEVEL_EN, level never exceeds 1.
5. ovf clear race: force a drop in the same cycle as ovf_clr=1 -> ovf stays 1. Next cycle ovf_clr=1 with no drop -> ovf=0.
6. Reset mid-packet: 5 words buffered, inf_ready=0, rstn=0 one cycle -> inf_valid=0 and ovf=0 at that edge, level=0. No stale word is emitted after rstn returns high.
